apb4_mem_slave: RTL and testbench
=================================

Name: apb4_mem_slave

Overview:
APB4-compliant memory-mapped slave backed by a parametrised register-file memory. It adds configurable data width, depth and wait states, byte-lane write strobes, alignment and range error detection, and registered responses. The block sits on the peripheral APB bus behind the bridge. It is the drop-in successor for the fixed 8-bit × 16 APB slave.

Parameters:
DATA_W, 32, data bus width in bits; must be 8, 16, 32 or 64.
DEPTH, 64, number of DATA_W-bit words; must be ≥ 2.
ADDR_W, 32, paddr width.
WAIT_CYCLES, 0, wait states inserted per transfer (0..15); pready stays low for this many access-phase cycles.

Ports:
pclk  in  1  bus clock; all logic on the rising edge.
presetn  in  1  asynchronous active-low reset.
paddr  in  ADDR_W  byte address.
psel  in  1  slave select.
penable  in  1  access-phase indicator.
pwrite  in  1  1 = write, 0 = read.
pwdata  in  DATA_W  write data.
pstrb  in  DATA_W/8  byte-lane write strobes.
prdata  out  DATA_W  read data, registered.
pready  out  1  transfer-complete, registered.
pslverr  out  1  error response, registered; valid only while pready = 1.

Behaviour:
- Derived constants: LSB = log2(DATA_W/8); word index = paddr[ADDR_W-1:LSB].
- Reset (presetn = 0, asynchronous):
  - state = IDLE; pready = 0, pslverr = 0, prdata = 0.
  - All memory words cleared to 0; wait counter cleared.
  - Reset asserted mid-transfer aborts that transfer with no memory update.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with psel = 1 and penable = 0 (setup phase), capture paddr, pwrite, pwdata and pstrb, and evaluate the error flag.
  - Load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else DONE.
  - Otherwise stay in IDLE.
- WAIT:
  - pready = 0. Decrement the counter each cycle.
  - Go to DONE on the edge where the counter reaches 1.
  - If psel = 0, abort to IDLE.
- DONE:
  - pready = 1 for exactly one cycle; pslverr = captured error flag.
  - Always return to IDLE on the next edge.
- Latency: with WAIT_CYCLES = 0, pready is high in the first access cycle (zero-wait APB). In general pready rises WAIT_CYCLES cycles after penable rises.
- Error flag = misaligned OR out_of_range:
  - misaligned: paddr[LSB-1:0] ≠ 0 (never set when DATA_W = 8).
  - out_of_range: word index ≥ DEPTH, compared on all upper bits with no aliasing.
- Write:
  - Commits on the edge ending DONE, only if psel = 1, penable = 1 and there is no error.
  - Each byte lane i is written only when pstrb[i] = 1.
  - pstrb = 0 is a legal no-op write with no error.
  - On error, memory is unchanged.
- Read:
  - prdata is loaded from memory[index] on the edge entering DONE.
  - On error, prdata = 0.
  - prdata returns to 0 when leaving DONE; it is 0 in every non-DONE cycle.
  - pstrb is ignored on reads.
- pslverr is 0 whenever pready = 0.
- Back-to-back transfers (DONE followed immediately by a new setup phase) are supported with no extra idle cycle.
- Read-after-write to the same address returns the new data.
- Protocol violations:
  - penable = 1 seen in IDLE without a preceding setup is ignored (no response).
  - psel dropping during WAIT aborts the transfer with no write.

Test Plan:
- Reset, then WAIT_CYCLES = 0: write 0xDEADBEEF to 0x04 with pstrb = 4'hF, then read 0x04. Required: pready high in the first access cycle of each transfer, prdata = 0xDEADBEEF, pslverr = 0.
- Byte strobes: word 0x08 holds 0x11223344; write 0xAABBCCDD with pstrb = 4'b0101, then read 0x08. Required: 0x11BB33DD.
- Errors: write to 0x102 (misaligned) and to 0x100 (index 64 = DEPTH). Required: pslverr = 1 with pready; a read of 0x100 returns prdata = 0; memory unchanged.
- WAIT_CYCLES = 3: read 0x0C. Required: pready low for 3 access cycles, high on the 4th with correct data.
- Abort and reset: drop psel during WAIT, and separately assert presetn = 0 during WAIT of a write. Required: no write occurs; all outputs 0 immediately; memory reads back 0 after reset.
- Back-to-back: a write to 0x10 immediately followed by a read of 0x10 with no idle cycle. Required: the read returns the written value and each transfer produces exactly one pready pulse.

Source files
------------

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master (bridge) and the memory-mapped slave.
interface apb4_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 slave backed by a DEPTH x DATA_W register-file memory with optional
// wait states, byte strobes and alignment/range error responses.
module apb4_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              presetn,
  apb4_mem_slave_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_LD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_p0;
  logic                write_p0;
  logic                err_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [STRB_W-1:0]   strb_p0;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   prdata_q;
  logic                pready_q;
  logic                pslverr_q;

  logic                setup, cap, enter_done, commit;
  logic [ADDR_W-1:0]   word_in;
  logic                err_in, err_cur, write_cur;
  logic [IDX_W-1:0]    idx_cur;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign setup   = bus.psel & ~bus.penable;
  assign cap     = (state_q == S_IDLE) & setup;
  assign word_in = bus.paddr >> LSB;
  // Full-width compare so high address bits can never alias into the array.
  assign err_in  = (|(bus.paddr & LSB_MASK)) | (word_in >= DEPTH_A);

  // With zero wait states DONE is entered on the setup edge itself, so the
  // response must come straight from the bus rather than the captured copy.
  assign err_cur    = cap ? err_in : err_p0;
  assign write_cur  = cap ? bus.pwrite : write_p0;
  assign idx_cur    = cap ? bus.paddr[LSB +: IDX_W] : idx_p0;
  assign enter_done = (state_d == S_DONE);
  assign commit     = (state_q == S_DONE) & bus.psel & bus.penable & write_p0 & ~err_p0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_p0    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (cap) err_p0 <= err_in;
      pready_q  <= enter_done;
      pslverr_q <= enter_done & err_cur;
      prdata_q  <= (enter_done & ~write_cur & ~err_cur) ? mem[idx_cur] : '0;
    end
  end

  // setup-phase capture
  always_ff @(posedge pclk) begin
    if (cap) begin
      idx_p0   <= bus.paddr[LSB +: IDX_W];
      write_p0 <= bus.pwrite;
      wdata_p0 <= bus.pwdata;
      strb_p0  <= bus.pstrb;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx_p0] <= merge_lanes(mem[idx_p0], wdata_p0, strb_p0);
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench driving a zero-wait and a three-wait slave over a shared master.
module tb_apb4_mem_slave;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb4_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  apb4_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  apb4_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0.slave));
  apb4_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .bus(bus3.slave));

  logic          sel;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;

  assign bus0.paddr   = paddr;
  assign bus0.psel    = psel & ~sel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.paddr   = paddr;
  assign bus3.psel    = psel & sel;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  logic          pready_m, pslverr_m;
  logic [DW-1:0] prdata_m;
  assign pready_m  = sel ? bus3.pready  : bus0.pready;
  assign pslverr_m = sel ? bus3.pslverr : bus0.pslverr;
  assign prdata_m  = sel ? bus3.prdata  : bus0.prdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_read;
    int          wait_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [2][DEPTH];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the transfer.
  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   d;
    int   w;
    int   n;
    logic err;
    d   = sel ? 1 : 0;
    err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    e.err     = err;
    e.is_read = !wr;
    e.wait_n  = sel ? 3 : 0;
    e.rdata   = '0;
    if (!err) begin
      w = int'(addr / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) mem_m[d][w][8*i +: 8] = data[8*i +: 8];
      end else begin
        e.rdata = mem_m[d][w];
      end
    end
    sb.push_back(e);
    paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge pclk);
      if (pready_m === 1'b1) break;
    end
    if (n == 40) chk("xfer_timeout", 1, 0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Write that loses psel after one wait cycle (selected slave must have wait states).
  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] data);
    paddr = addr; pwrite = 1'b1; pwdata = data; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    idle(2);
  endtask

  task automatic reset_in_wait(input logic [31:0] addr, input logic [31:0] data);
    paddr = addr; pwrite = 1'b1; pwdata = data; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("rst_mid_pready0",  bus0.pready,  0);
    chk("rst_mid_pslverr0", bus0.pslverr, 0);
    chk("rst_mid_prdata0",  bus0.prdata,  0);
    chk("rst_mid_pready3",  bus3.pready,  0);
    chk("rst_mid_pslverr3", bus3.pslverr, 0);
    chk("rst_mid_prdata3",  bus3.prdata,  0);
    psel = 1'b0; penable = 1'b0;
    clear_model();
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    idle(1);
  endtask

  // Monitor: pops one expectation per pready pulse and checks idle-cycle outputs.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge pclk);
      if (presetn !== 1'b1) begin
        cnt = 0;
        continue;
      end
      if (pready_m === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wait_states", cnt, e.wait_n);
          chk("pslverr", pslverr_m, e.err);
          if (e.is_read) chk("prdata", prdata_m, e.rdata);
        end
        cnt = 0;
      end else begin
        chk("idle_pslverr", pslverr_m, 0);
        chk("idle_prdata", prdata_m, 0);
        if (psel && penable) cnt++;
        else if (!psel) cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int          r;
    logic [31:0] a;
    sel = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = '0; pstrb = '0;
    clear_model();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready0",  bus0.pready,  0);
    chk("rst_pslverr0", bus0.pslverr, 0);
    chk("rst_prdata0",  bus0.prdata,  0);
    chk("rst_pready3",  bus3.pready,  0);
    chk("rst_pslverr3", bus3.pslverr, 0);
    chk("rst_prdata3",  bus3.prdata,  0);
    @(negedge pclk);
    presetn = 1'b1;
    idle(1);

    // zero-wait write/read
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    idle(1);
    xfer(1'b0, 32'h04, 32'h0, 4'h0);
    idle(1);

    // byte strobes
    xfer(1'b1, 32'h08, 32'h11223344, 4'hF);
    idle(1);
    xfer(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101);
    idle(1);
    xfer(1'b0, 32'h08, 32'h0, 4'h0);

    // errors and high-address aliasing
    xfer(1'b1, 32'h102, 32'h55555555, 4'hF);
    xfer(1'b1, 32'h100, 32'h66666666, 4'hF);
    xfer(1'b0, 32'h100, 32'h0, 4'h0);
    xfer(1'b1, 32'h8000_0004, 32'h77777777, 4'hF);
    xfer(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    xfer(1'b0, 32'h04, 32'h0, 4'h0);
    xfer(1'b0, 32'h00, 32'h0, 4'h0);

    // empty strobe is a silent no-op
    xfer(1'b1, 32'h04, 32'hFFFFFFFF, 4'h0);
    xfer(1'b0, 32'h04, 32'h0, 4'h0);

    // penable without a setup phase draws no response
    psel = 1'b1; penable = 1'b1; paddr = 32'h04; pwrite = 1'b1;
    idle(3);
    psel = 1'b0; penable = 1'b0;
    idle(2);

    // three wait states
    sel = 1'b1;
    xfer(1'b0, 32'h0C, 32'h0, 4'h0);
    xfer(1'b1, 32'h0C, 32'hCAFEF00D, 4'hF);
    idle(1);
    xfer(1'b0, 32'h0C, 32'h0, 4'h0);
    xfer(1'b1, 32'h102, 32'h1, 4'hF);

    // psel dropped during the wait states
    xfer(1'b1, 32'h14, 32'h12345678, 4'hF);
    idle(1);
    abort_xfer(32'h14, 32'hBAD0BAD0);
    xfer(1'b0, 32'h14, 32'h0, 4'h0);
    idle(1);

    // back-to-back on both slaves
    sel = 1'b0;
    xfer(1'b1, 32'h10, 32'h0BADF00D, 4'hF);
    xfer(1'b0, 32'h10, 32'h0, 4'h0);
    idle(1);
    sel = 1'b1;
    xfer(1'b1, 32'h10, 32'hFEEDFACE, 4'hF);
    xfer(1'b0, 32'h10, 32'h0, 4'h0);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      sel = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(DEPTH + $urandom_range(0, 100)) * 4;
      else             a = $urandom() | 32'h0000_1000;
      xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
      idle(int'($urandom_range(0, 2)));
    end

    // reset during a write's wait states
    sel = 1'b1;
    xfer(1'b1, 32'h14, 32'hA5A5A5A5, 4'hF);
    idle(1);
    reset_in_wait(32'h14, 32'h5A5A5A5A);
    xfer(1'b0, 32'h14, 32'h0, 4'h0);
    xfer(1'b0, 32'h0C, 32'h0, 4'h0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0);
    sel = 1'b0;
    xfer(1'b0, 32'h04, 32'h0, 4'h0);
    xfer(1'b0, 32'h08, 32'h0, 4'h0);
    idle(2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge pclk);
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
